vdp_reg_write_arbiter: RTL
==========================

// Module: vdp_reg_write_arbiter
// PURPOSE
// - Sits between the copper's register write port and the VDP register file; merges copper writes with host (CPU) writes.
// - Copper writes pass through a small FIFO so that host traffic never drops them.
// - Host writes take priority; a starvation limiter guarantees the copper regular service.
// - Produces one registered register write per cycle toward the VDP register file.
// PARAMETERS
// - ADDR_WIDTH    6   register address width
// - DATA_WIDTH    16  register data width
// - FIFO_DEPTH    4   copper FIFO entries; power of 2, >= 2
// - STARVE_LIMIT  3   consecutive host grants allowed while the FIFO is non-empty; >= 1
// PORTS
// - clk                  in   1           system clock
// - reset_n              in   1           synchronous reset, active-low
// - host_write_en        in   1           host write valid; held until accepted
// - host_address         in   ADDR_WIDTH  host register address
// - host_data            in   DATA_WIDTH  host write data
// - host_write_ready     out  1           host write accepted when en && ready
// - copper_write_en      in   1           copper write valid (single-cycle pulse)
// - copper_address       in   ADDR_WIDTH  copper register address
// - copper_data          in   DATA_WIDTH  copper write data
// - copper_write_ready   out  1           FIFO has space (count < FIFO_DEPTH)
// - flush                in   1           discard all queued copper writes
// - reg_write_en         out  1           register-file write strobe
// - reg_write_address    out  ADDR_WIDTH  register-file address
// - reg_write_data       out  DATA_WIDTH  register-file data
// - fifo_level           out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
// - copper_overflow      out  1           sticky: copper write dropped because the FIFO was full
// BEHAVIOUR
// - Reset (reset_n low at posedge):
//   - reg_write_en, reg_write_address, reg_write_data, fifo_level, copper_overflow, starve count and force flag all = 0.
//   - While reset_n is low, host_write_ready = 0 and copper_write_ready = 0.
//   - Reset asserted mid-drain discards all queued entries.
// - Push: copper_write_en && count < FIFO_DEPTH -> enqueue {address, data}.
//   - copper_write_en while full -> entry dropped, copper_overflow <= 1.
//   - copper_overflow clears only on reset.
// - copper_write_ready is combinational from the registered count.
//   - A pop in the same cycle does not raise ready early.
// - Grant, evaluated each cycle:
//   - force flag set and FIFO non-empty -> copper granted; host_write_ready = 0.
//   - else host_write_en -> host granted; host_write_ready = 1.
//   - else FIFO non-empty -> copper granted (pop head).
//   - else idle.
// - Output register:
//   - The granted write appears on reg_write_* the cycle after grant; reg_write_en is high for exactly 1 cycle per write.
//   - On idle cycles, address and data hold their last values.
// - Latency:
//   - Host: 1 cycle from acceptance.
//   - Copper into an empty FIFO with host idle: push at N, pop at N+1, reg_write_en at N+2.
// - Same-cycle push and pop are allowed; count stays unchanged.
// - Starvation limiter:
//   - Starve count increments on every host grant while the FIFO is non-empty.
//   - When the count reaches STARVE_LIMIT, the force flag is set for the next cycle.
//   - A copper grant clears both count and flag; so does an empty FIFO.
// - Ordering: copper writes leave in push order; host writes never reorder among themselves.
// - Flush:
//   - Next cycle: count = 0, starve count and force flag cleared.
//   - A copper push in the flush cycle is dropped and does not set copper_overflow.
//   - A host grant in the flush cycle completes normally.
//   - A copper grant in the flush cycle is suppressed: no reg_write_en.
// - Pointers wrap modulo FIFO_DEPTH; count is tracked separately so full and empty are unambiguous.
// STRUCTURE
// - vdp_defines.vh (shared include): VDP_REG_ADDR_WIDTH = 6, VDP_REG_DATA_WIDTH = 16.
// - Sub-module vdp_sync_fifo: parameterised width/depth; push, pop, flush, count, head data (registered storage).
// - Top level holds the grant logic, starvation counter and output register.
// TESTING
// - Single copper write {0x12, 0xBEEF} at cycle 0, host idle
//   -> reg_write_en at cycle 2 with 0x12/0xBEEF; fifo_level 1 -> 0.
// - Host {0x05, 0x1111} and copper {0x06, 0x2222} in the same cycle
//   -> 0x05/0x1111 out at +1, 0x06/0x2222 out at +2.
// - Host writes every cycle, 5 copper pushes back-to-back with STARVE_LIMIT = 8, FIFO_DEPTH = 4
//   -> copper_write_ready low after the 4th push; 5th dropped; copper_overflow = 1 until reset.
// - Host writes every cycle, FIFO holding 1 entry, STARVE_LIMIT = 3
//   -> 3 host writes out, then host_write_ready = 0 for 1 cycle and the copper entry is emitted; host resumes with no host write lost.
// - Flush with 3 queued entries plus a host write in the same cycle
//   -> host write emitted; fifo_level = 0 next cycle; no copper write ever emitted.
// - reset_n low while draining 2 entries
//   -> reg_write_en = 0 next cycle; fifo_level = 0; copper_overflow = 0; no stale entry emitted after release.

Source files
------------

// File: rtl/vdp_reg_write_arbiter_pkg.sv
// Shared widths and types for the VDP register write arbiter.
// Default register-file widths match the VDP register file.
package vdp_reg_write_arbiter_pkg;

  localparam int VDP_REG_ADDR_WIDTH = 6;
  localparam int VDP_REG_DATA_WIDTH = 16;

  typedef enum logic [1:0] {
    GRANT_IDLE   = 2'd0,
    GRANT_HOST   = 2'd1,
    GRANT_COPPER = 2'd2
  } grant_e;

endpackage

// File: rtl/vdp_reg_write_arbiter_fifo.sv
// Synchronous FIFO for queued copper writes.
// Occupancy is counted separately from the pointers so that full and empty never alias.
module vdp_sync_fifo #(
  parameter int WIDTH = 22,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] head_o,
  output logic [CNT_W-1:0] count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  // A flush overrides any push or pop issued in the same cycle.
  assign do_push = push_i && !flush_i && (count_q != CNT_W'(DEPTH));
  assign do_pop  = pop_i && !flush_i && (count_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/vdp_reg_write_arbiter.sv
// Merges host and copper register writes into one registered write stream,
// host first, with a starvation limiter guaranteeing copper service.
module vdp_reg_write_arbiter
  import vdp_reg_write_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH   = VDP_REG_ADDR_WIDTH,
  parameter int DATA_WIDTH   = VDP_REG_DATA_WIDTH,
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 3,
  localparam int LVL_W       = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  host_write_en,
  input  logic [ADDR_WIDTH-1:0] host_address,
  input  logic [DATA_WIDTH-1:0] host_data,
  output logic                  host_write_ready,
  input  logic                  copper_write_en,
  input  logic [ADDR_WIDTH-1:0] copper_address,
  input  logic [DATA_WIDTH-1:0] copper_data,
  output logic                  copper_write_ready,
  input  logic                  flush,
  output logic                  reg_write_en,
  output logic [ADDR_WIDTH-1:0] reg_write_address,
  output logic [DATA_WIDTH-1:0] reg_write_data,
  output logic [LVL_W-1:0]      fifo_level,
  output logic                  copper_overflow
);

  localparam int ENTRY_W  = ADDR_WIDTH + DATA_WIDTH;
  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

  logic [ENTRY_W-1:0]    fifo_head;
  logic                  fifo_empty, fifo_full;
  grant_e                grant;

  logic                  out_en_q, out_en_d;
  logic [ADDR_WIDTH-1:0] out_addr_q, out_addr_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  overflow_q, overflow_d;
  logic [STARVE_W-1:0]   starve_q, starve_d;
  logic                  force_q, force_d;

  vdp_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (copper_write_en),
    .pop_i   (grant == GRANT_COPPER),
    .flush_i (flush),
    .data_i  ({copper_address, copper_data}),
    .head_o  (fifo_head),
    .count_o (fifo_level)
  );

  assign fifo_empty = (fifo_level == '0);
  assign fifo_full  = (fifo_level == LVL_W'(FIFO_DEPTH));

  assign host_write_ready   = reset_n && !(force_q && !fifo_empty);
  assign copper_write_ready = reset_n && !fifo_full;

  always_comb begin
    grant = GRANT_IDLE;
    if (force_q && !fifo_empty)  grant = GRANT_COPPER;
    else if (host_write_en)      grant = GRANT_HOST;
    else if (!fifo_empty)        grant = GRANT_COPPER;
  end

  always_comb begin
    out_en_d   = 1'b0;
    out_addr_d = out_addr_q;
    out_data_d = out_data_q;
    case (grant)
      GRANT_HOST: begin
        out_en_d   = 1'b1;
        out_addr_d = host_address;
        out_data_d = host_data;
      end
      GRANT_COPPER: begin
        // The head is popped but discarded when a flush lands in the same cycle.
        if (!flush) begin
          out_en_d   = 1'b1;
          out_addr_d = fifo_head[ENTRY_W-1 -: ADDR_WIDTH];
          out_data_d = fifo_head[DATA_WIDTH-1:0];
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    overflow_d = overflow_q | (copper_write_en && fifo_full && !flush);
    starve_d   = starve_q;
    force_d    = force_q;
    if (flush || fifo_empty || grant == GRANT_COPPER) begin
      starve_d = '0;
      force_d  = 1'b0;
    end else if (grant == GRANT_HOST) begin
      if (starve_q != STARVE_W'(STARVE_LIMIT)) starve_d = starve_q + 1'b1;
      force_d = (starve_d == STARVE_W'(STARVE_LIMIT));
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_en_q   <= 1'b0;
      out_addr_q <= '0;
      out_data_q <= '0;
      overflow_q <= 1'b0;
      starve_q   <= '0;
      force_q    <= 1'b0;
    end else begin
      out_en_q   <= out_en_d;
      out_addr_q <= out_addr_d;
      out_data_q <= out_data_d;
      overflow_q <= overflow_d;
      starve_q   <= starve_d;
      force_q    <= force_d;
    end
  end

  assign reg_write_en      = out_en_q;
  assign reg_write_address = out_addr_q;
  assign reg_write_data    = out_data_q;
  assign copper_overflow   = overflow_q;

endmodule
